// File: rtl/imm_ext_pipe.sv
// Registered RISC-V immediate generator with opcode auto-decode,
// CSR/shift formats, illegal flag and a one-entry valid/ready output.
module imm_ext_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);

    localparam logic [2:0] T_I    = 3'b000;
    localparam logic [2:0] T_S    = 3'b001;
    localparam logic [2:0] T_B    = 3'b010;
    localparam logic [2:0] T_J    = 3'b011;
    localparam logic [2:0] T_U    = 3'b100;
    localparam logic [2:0] T_Z    = 3'b101;
    localparam logic [2:0] T_SH   = 3'b110;
    localparam logic [2:0] T_NONE = 3'b111;

    logic [2:0]      auto_type;
    logic [2:0]      sel_type;
    logic [31:0]     raw;
    logic            sext;
    logic [XLEN-1:0] imm;
    logic            accept;

    always_comb begin
        auto_type = T_NONE;
        unique case (in_instr[6:0])
            7'b0000011, 7'b1100111: auto_type = T_I;
            7'b0010011: auto_type = (in_instr[13:12] == 2'b01) ? T_SH : T_I;
            7'b0100011: auto_type = T_S;
            7'b1100011: auto_type = T_B;
            7'b1101111: auto_type = T_J;
            7'b0110111, 7'b0010111: auto_type = T_U;
            7'b1110011: auto_type = in_instr[14] ? T_Z : T_I;
            default: auto_type = T_NONE;
        endcase
    end

    assign sel_type = AUTO_DECODE ? auto_type : imm_src;

    // Formats are first assembled at 32 bits, then widened to XLEN.
    always_comb begin
        raw  = '0;
        sext = 1'b1;
        case (sel_type)
            T_I: raw = {{20{in_instr[31]}}, in_instr[31:20]};
            T_S: raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_B: raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
            T_J: raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
            T_U: raw = {in_instr[31:12], 12'b0};
            T_Z: begin
                raw  = {27'b0, in_instr[19:15]};
                sext = 1'b0;
            end
            T_SH: begin
                raw  = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                    : {27'b0, in_instr[24:20]};
                sext = 1'b0;
            end
            default: begin
                raw  = '0;
                sext = 1'b0;
            end
        endcase
    end

    assign imm      = sext ? XLEN'($signed(raw)) : XLEN'(raw);
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready & !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_type    <= T_NONE;
            out_illegal <= 1'b0;
            out_instr   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_imm     <= imm;
            out_type    <= sel_type;
            out_illegal <= (sel_type == T_NONE);
            out_instr   <= in_instr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: 32-bit auto, 64-bit auto and 32-bit manual
// instances share stimulus and are checked against an arithmetic model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic [2:0]  imm_src = 3'b000;

    logic        rdy32, rdy64, rdym;
    logic        val32, val64, valm;
    logic [31:0] imm32, immm;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64, typm;
    logic        ill32, ill64, illm;
    logic [31:0] ins32, ins64, insm;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy32), .in_instr(in_instr), .imm_src(imm_src),
        .out_valid(val32), .out_ready(out_ready), .out_imm(imm32),
        .out_type(typ32), .out_illegal(ill32), .out_instr(ins32));

    imm_ext_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy64), .in_instr(in_instr), .imm_src(imm_src),
        .out_valid(val64), .out_ready(out_ready), .out_imm(imm64),
        .out_type(typ64), .out_illegal(ill64), .out_instr(ins64));

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) um (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(rdym), .in_instr(in_instr), .imm_src(imm_src),
        .out_valid(valm), .out_ready(out_ready), .out_imm(immm),
        .out_type(typm), .out_illegal(illm), .out_instr(insm));

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode by opcode name, straight from the ISA table.
    function automatic logic [2:0] m_decode(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        if (op == 7'h03 || op == 7'h67) return 3'd0;
        if (op == 7'h13) return (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h6F) return 3'd3;
        if (op == 7'h37 || op == 7'h17) return 3'd4;
        if (op == 7'h73) return w[14] ? 3'd5 : 3'd0;
        return 3'd7;
    endfunction

    // Immediate as a signed integer value, then reduced to XLEN bits.
    function automatic logic [63:0] m_ext(input logic [31:0] w,
                                          input logic [2:0] t, input int xl);
        longint v;
        longint s;
        s = w[31] ? 64'd1 : 64'd0;
        case (t)
            3'd0: v = longint'(w[31:20]) - s * 4096;
            3'd1: v = longint'({w[31:25], w[11:7]}) - s * 4096;
            3'd2: v = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2
                      - s * 8192;
            3'd3: v = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2
                      - s * (64'd1 << 21);
            3'd4: v = longint'(w[31:12]) * 4096 - s * (64'd1 << 32);
            3'd5: v = longint'(w[19:15]);
            3'd6: v = (xl == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        if (xl == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    int          xl [3] = '{32, 64, 32};
    bit          au [3] = '{1'b1, 1'b1, 1'b0};
    bit          started = 1'b0;
    logic        m_valid [3];
    logic        m_rs    [3];
    logic [63:0] m_imm   [3];
    logic [2:0]  m_type  [3];
    logic        m_ill   [3];
    logic [31:0] m_instr [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [2:0] t;
            t = au[i] ? m_decode(in_instr) : imm_src;
            if (rst) begin
                m_valid[i] = 1'b0;
                m_rs[i]    = 1'b1;
                m_imm[i]   = '0;
                m_type[i]  = 3'd7;
                m_ill[i]   = 1'b0;
                m_instr[i] = '0;
            end else if (flush) begin
                m_valid[i] = 1'b0;
                m_rs[i]    = 1'b0;
            end else if (in_valid && (!m_valid[i] || out_ready)) begin
                m_valid[i] = 1'b1;
                m_rs[i]    = 1'b0;
                m_imm[i]   = m_ext(in_instr, t, xl[i]);
                m_type[i]  = t;
                m_ill[i]   = (t == 3'd7);
                m_instr[i] = in_instr;
            end else if (out_ready) begin
                m_valid[i] = 1'b0;
            end
        end
        if (rst) started = 1'b1;
    end

    logic        d_valid [3];
    logic        d_rdy   [3];
    logic [63:0] d_imm   [3];
    logic [2:0]  d_type  [3];
    logic        d_ill   [3];
    logic [31:0] d_instr [3];

    always_comb begin
        d_valid = '{val32, val64, valm};
        d_rdy   = '{rdy32, rdy64, rdym};
        d_imm   = '{{32'b0, imm32}, imm64, {32'b0, immm}};
        d_type  = '{typ32, typ64, typm};
        d_ill   = '{ill32, ill64, illm};
        d_instr = '{ins32, ins64, insm};
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_valid", i), 64'(d_valid[i]),
                    64'(m_valid[i]));
                chk($sformatf("u%0d_in_ready", i), 64'(d_rdy[i]),
                    64'(!m_valid[i] || out_ready));
                if (m_valid[i] || m_rs[i]) begin
                    chk($sformatf("u%0d_imm", i), d_imm[i], m_imm[i]);
                    chk($sformatf("u%0d_type", i), 64'(d_type[i]),
                        64'(m_type[i]));
                    chk($sformatf("u%0d_illegal", i), 64'(d_ill[i]),
                        64'(m_ill[i]));
                    chk($sformatf("u%0d_instr", i), 64'(d_instr[i]),
                        64'(m_instr[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_instr = w;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(val32), 64'd0);
        chk("rst_type", 64'(typ32), 64'd7);
        chk("rst_imm", 64'(imm32), 64'd0);
        chk("rst_ready", 64'(rdy32), 64'd1);

        push(32'hFFF00093);
        chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);
        chk("addi_type", 64'(typ32), 64'd0);
        chk("addi_valid", 64'(val32), 64'd1);
        push(32'hFE112E23);
        chk("sw_imm", 64'(imm32), 64'hFFFFFFFC);
        chk("sw_type", 64'(typ32), 64'd1);
        push(32'hFF9FF06F);
        chk("jal_imm", 64'(imm32), 64'hFFFFFFF8);
        chk("jal_type", 64'(typ32), 64'd3);
        push(32'h3002D073);
        chk("csr_imm", 64'(imm32), 64'h5);
        chk("csr_type", 64'(typ32), 64'd5);
        push(32'h00309093);
        chk("slli_imm", 64'(imm32), 64'h3);
        chk("slli_type", 64'(typ32), 64'd6);
        push(32'h123452B7);
        chk("lui_imm", 64'(imm32), 64'h12345000);
        chk("lui_type", 64'(typ32), 64'd4);
        push(32'h00000033);
        chk("rtype_imm", 64'(imm32), 64'h0);
        chk("rtype_type", 64'(typ32), 64'd7);
        chk("rtype_ill", 64'(ill32), 64'd1);
        push(32'h800002B7);
        chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("lui32_imm", 64'(imm32), 64'h80000000);
        push(32'h03F09093);
        chk("slli63_imm", imm64, 64'd63);
        chk("slli63_type", 64'(typ64), 64'd6);
        chk("slli31_imm", 64'(imm32), 64'd31);

        push(32'hFFF00093);
        out_ready = 1'b0;
        in_instr = 32'h123452B7;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready", 64'(rdy32), 64'd0);
            chk("bp_imm", 64'(imm32), 64'hFFFFFFFF);
            chk("bp_valid", 64'(val32), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_lui_imm", 64'(imm32), 64'h12345000);
        chk("bp_lui_valid", 64'(val32), 64'd1);

        flush = 1'b1;
        in_instr = 32'hFE112E23;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(val32), 64'd0);
        tick();
        chk("flush_drop", 64'(val32), 64'd0);

        push(32'hFFF00093);
        chk("pre_rst_valid", 64'(val32), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", 64'(val32), 64'd0);
        chk("mid_rst_imm", 64'(imm32), 64'd0);
        chk("mid_rst_type", 64'(typ32), 64'd7);
        chk("mid_rst_ill", 64'(ill32), 64'd0);
        chk("mid_rst_instr", 64'(ins32), 64'd0);

        imm_src = 3'b010;
        push(32'h00000463);
        chk("man_imm", 64'(immm), 64'h8);
        chk("man_type", 64'(typm), 64'd2);
        imm_src = 3'b111;
        push(32'hFFF00093);
        chk("man_none_imm", 64'(immm), 64'h0);
        chk("man_none_ill", 64'(illm), 64'd1);
        in_valid = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, registered immediate-generation stage for the RISC-V datapath. Extends the combinational I/S/B/J/U extender with:
- XLEN generalisation (32/64).
- Optional opcode-based auto-decode of the immediate type.
- Two extra formats: CSR zimm and shift amount.
- An illegal-format flag.
- A one-entry valid/ready output register with flush.

It sits between instruction fetch/decode and the ALU operand mux.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
AUTO_DECODE, 1, 1 = derive the immediate type from the opcode/funct3; 0 = use the imm_src port.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard the held entry and the accepted input this cycle
in_valid  input  1  instruction present
in_ready  output  1  stage can accept
in_instr  input  32  instruction word
imm_src  input  3  external type select; ignored when AUTO_DECODE=1
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  extended immediate
out_type  output  3  type actually applied
out_illegal  output  1  no immediate format applies
out_instr  output  32  registered copy of in_instr

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Type encoding:
  - 000 I: sign-extended instr[31:20].
  - 001 S: sign-extended {instr[31:25],instr[11:7]}.
  - 010 B: sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - 011 J: sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - 100 U: {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN.
  - 101 Z: zero-extended instr[19:15].
  - 110 SH: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 111 NONE: imm = 0, illegal = 1.
- Auto-decode (AUTO_DECODE=1), keyed on opcode instr[6:0]:
  - 0000011 load, 1100111 jalr → I.
  - 0010011 → SH if funct3 is 001 or 101, else I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 1110011 → Z if instr[14]=1, else I.
  - Any other opcode → NONE.
- Manual mode (AUTO_DECODE=0): imm_src is used directly. The value 111 gives NONE (imm=0, illegal=1).
- Illegal flag: out_illegal=1 only for NONE.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept = in_valid & in_ready & !flush.
  - On accept: out_imm, out_type, out_illegal and out_instr load the extension result next edge, and out_valid=1.
  - If out_valid & out_ready and there is no accept: out_valid→0 next edge.
- Latency: exactly 1 cycle from accept to out_valid. Full throughput of 1 per cycle when out_ready is held high.
- Backpressure: while out_valid & !out_ready, all out_* hold stable, and in_ready=0.
- Flush:
  - Next edge out_valid=0.
  - Any input presented that cycle is dropped.
  - Data registers may keep stale values.
  - Flush takes precedence over accept and over rst-free operation. rst takes precedence over flush.
- Reset: out_valid=0, out_imm=0, out_type=3'b111, out_illegal=0, out_instr=0.
  - Reset mid-transfer discards the entry.
  - in_ready=1 in the first cycle after reset.
- Width rule: all sign extension uses instr[31] as the sign bit, replicated to XLEN. No truncation occurs for XLEN=32.

Test Plan:
1. XLEN=32, auto, back-to-back, out_ready=1:
   - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, type 000.
   - 0xFE112E23 (sw -4) → 0xFFFFFFFC, type 001.
   - 0xFF9FF06F (jal -8) → 0xFFFFFFF8, type 011.
   - Each result valid exactly 1 cycle after accept; no bubbles.
2. Special formats:
   - 0x3002D073 (csrrwi zimm 5) → imm 0x5, type 101.
   - 0x00309093 (slli 3) → imm 0x3, type 110.
   - 0x123452B7 (lui) → 0x12345000, type 100.
   - 0x00000033 (R-type) → imm 0, type 111, out_illegal=1.
3. XLEN=64, auto:
   - 0x800002B7 → 0xFFFFFFFF80000000.
   - 0x03F09093 (slli 63) → imm 63, type 110.
4. Backpressure:
   - Accept 0xFFF00093, then hold out_ready=0 for 3 cycles while in_valid=1 with 0x123452B7.
   - Required: in_ready=0 and out_imm stays 0xFFFFFFFF throughout.
   - On out_ready=1, the lui result appears the following cycle.
5. Flush:
   - With out_valid=1, assert flush together with in_valid.
   - Required: next cycle out_valid=0, and the flushed input never appears at the output.
6. Reset and manual mode:
   - Assert rst while out_valid=1 → next cycle all outputs at reset values.
   - AUTO_DECODE=0, imm_src=010, instr 0x00000463 → imm 0x8, type 010.
